// File: rtl/sequence_pkg.sv
// Shared definitions for the sequence-memory game: state codes, playback phases,
// default parameter values and the address-width helper.
package sequence_pkg;

    localparam int    DEF_N_CH        = 4;
    localparam int    DEF_DEPTH       = 16;
    localparam int    DEF_SHOW_CYC    = 500;
    localparam int    DEF_TIMEOUT_CYC = 5000;
    localparam string DEF_INIT_FILE   = "ram_init.txt";

    localparam logic [3:0] ST_IDLE        = 4'h0;
    localparam logic [3:0] ST_GRAVA       = 4'h1;
    localparam logic [3:0] ST_MOSTRA      = 4'h2;
    localparam logic [3:0] ST_ESPERA      = 4'h3;
    localparam logic [3:0] ST_COMPARA     = 4'h4;
    localparam logic [3:0] ST_PROX_RODADA = 4'h5;
    localparam logic [3:0] ST_ACERTO      = 4'hA;
    localparam logic [3:0] ST_ERRO        = 4'hE;
    localparam logic [3:0] ST_TIMEOUT     = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE        = ST_IDLE,
        S_GRAVA       = ST_GRAVA,
        S_MOSTRA      = ST_MOSTRA,
        S_ESPERA      = ST_ESPERA,
        S_COMPARA     = ST_COMPARA,
        S_PROX_RODADA = ST_PROX_RODADA,
        S_ACERTO      = ST_ACERTO,
        S_ERRO        = ST_ERRO,
        S_TIMEOUT     = ST_TIMEOUT
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_ON,
        PH_OFF
    } phase_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sequence_game_engine_if.sv
// Player/debug signal bundle of the sequence game engine; master drives the
// buttons and start request, slave is the engine.
interface sequence_game_engine_if #(
    parameter int N_CH = 4,
    parameter int AW   = 4
);
    logic            iniciar;
    logic            modo;
    logic [N_CH-1:0] chaves;
    logic [N_CH-1:0] leds;
    logic            pronto;
    logic            acertou;
    logic            errou;
    logic            timeout;
    logic [AW-1:0]   db_rodada;
    logic [AW-1:0]   db_endereco;
    logic [N_CH-1:0] db_jogada;
    logic [3:0]      db_estado;

    modport master (
        output iniciar, modo, chaves,
        input  leds, pronto, acertou, errou, timeout,
        input  db_rodada, db_endereco, db_jogada, db_estado
    );

    modport slave (
        input  iniciar, modo, chaves,
        output leds, pronto, acertou, errou, timeout,
        output db_rodada, db_endereco, db_jogada, db_estado
    );
endinterface

// File: rtl/sync_ram_param.sv
// DEPTH x N_CH sequence memory: synchronous write, registered 1-cycle read.
module sync_ram_param
    import sequence_pkg::*;
#(
    parameter int    N_CH      = DEF_N_CH,
    parameter int    DEPTH     = DEF_DEPTH,
    parameter string INIT_FILE = DEF_INIT_FILE,
    localparam int   AW        = addr_w(DEPTH)
) (
    input  logic            clock,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [N_CH-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [N_CH-1:0] rdata
);
    logic [N_CH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/sequence_game_engine.sv
// Sequence-memory game core: RAM playback, edge-qualified jogada capture and round growth.
// Define SEQUENCE_TIMEOUT_EN to add the per-jogada idle timeout and the TIMEOUT state.
module sequence_game_engine
    import sequence_pkg::*;
#(
    parameter int    N_CH        = DEF_N_CH,
    parameter int    DEPTH       = DEF_DEPTH,
    parameter int    SHOW_CYC    = DEF_SHOW_CYC,
    parameter int    TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter string INIT_FILE   = DEF_INIT_FILE
) (
    input logic                   clock,
    input logic                   reset_n,
    sequence_game_engine_if.slave bus
);
    localparam int AW = addr_w(DEPTH);
    localparam int PW = $clog2(SHOW_CYC + 1);

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rodada_q, rodada_d, endereco_q, endereco_d;
    logic [N_CH-1:0] jogada_q, jogada_d, rdata;
    logic            modo_q, modo_d, prev_any, press, we, show_last;
`ifdef SEQUENCE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_expired;
    assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYC - 1));
`endif

    assign press     = (|bus.chaves) & ~prev_any;
    assign show_last = (cnt_q == PW'(SHOW_CYC - 1));

    // Read address follows the next endereco so rdata always matches the current one.
    sync_ram_param #(.N_CH(N_CH), .DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_ram (
        .clock(clock), .we(we), .waddr(rodada_q), .wdata(bus.chaves),
        .raddr(endereco_d), .rdata(rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_SETUP;
            cnt_q      <= '0;
            rodada_q   <= '0;
            endereco_q <= '0;
            jogada_q   <= '0;
            modo_q     <= 1'b0;
            prev_any   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            rodada_q   <= rodada_d;
            endereco_q <= endereco_d;
            jogada_q   <= jogada_d;
            modo_q     <= modo_d;
            prev_any   <= |bus.chaves;
        end
    end

`ifdef SEQUENCE_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = PH_SETUP;
        cnt_d      = '0;
        rodada_d   = rodada_q;
        endereco_d = endereco_q;
        jogada_d   = jogada_q;
        modo_d     = modo_q;
        we         = 1'b0;
`ifdef SEQUENCE_TIMEOUT_EN
        tmo_d      = '0;
`endif
        case (state_q)
            S_IDLE, S_ACERTO, S_ERRO, S_TIMEOUT: begin
                if (bus.iniciar) begin
                    rodada_d   = '0;
                    endereco_d = '0;
                    jogada_d   = '0;
                    modo_d     = bus.modo;
                    state_d    = bus.modo ? S_GRAVA : S_MOSTRA;
                end
            end
            S_GRAVA: begin
                if (press) begin
                    we       = 1'b1;
                    jogada_d = bus.chaves;
                    state_d  = S_MOSTRA;
                end
`ifdef SEQUENCE_TIMEOUT_EN
                else if (tmo_expired) state_d = S_TIMEOUT;
                else                  tmo_d   = tmo_q + 1'b1;
`endif
            end
            S_MOSTRA: begin
                phase_d = phase_q;
                cnt_d   = cnt_q + 1'b1;
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_ON;
                        cnt_d   = '0;
                    end
                    PH_ON: begin
                        if (show_last) begin
                            phase_d = PH_OFF;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        if (show_last) begin
                            cnt_d = '0;
                            if (endereco_q == rodada_q) begin
                                endereco_d = '0;
                                state_d    = S_ESPERA;
                            end else begin
                                endereco_d = endereco_q + 1'b1;
                                phase_d    = PH_ON;
                            end
                        end
                    end
                endcase
            end
            S_ESPERA: begin
                if (press) begin
                    jogada_d = bus.chaves;
                    state_d  = S_COMPARA;
                end
`ifdef SEQUENCE_TIMEOUT_EN
                else if (tmo_expired) state_d = S_TIMEOUT;
                else                  tmo_d   = tmo_q + 1'b1;
`endif
            end
            S_COMPARA: begin
                if (jogada_q != rdata) begin
                    state_d = S_ERRO;
                end else if (endereco_q < rodada_q) begin
                    endereco_d = endereco_q + 1'b1;
                    state_d    = S_ESPERA;
                end else begin
                    state_d = S_PROX_RODADA;
                end
            end
            S_PROX_RODADA: begin
                if (rodada_q == AW'(DEPTH - 1)) begin
                    state_d = S_ACERTO;
                end else begin
                    rodada_d   = rodada_q + 1'b1;
                    endereco_d = '0;
                    state_d    = modo_q ? S_GRAVA : S_MOSTRA;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.leds        = ((state_q == S_MOSTRA && phase_q == PH_ON) || state_q == S_ERRO)
                             ? rdata : '0;
    assign bus.pronto      = (state_q == S_ACERTO) || (state_q == S_ERRO) || (state_q == S_TIMEOUT);
    assign bus.acertou     = (state_q == S_ACERTO);
    assign bus.errou       = (state_q == S_ERRO);
`ifdef SEQUENCE_TIMEOUT_EN
    assign bus.timeout     = (state_q == S_TIMEOUT);
`else
    assign bus.timeout     = 1'b0;
`endif
    assign bus.db_rodada   = rodada_q;
    assign bus.db_endereco = endereco_q;
    assign bus.db_jogada   = jogada_q;
    assign bus.db_estado   = state_q;
endmodule
